// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract sequencer.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    // Requester side: issues operands, observes status/result
    modport master (
        output start, sub, op_a, op_b,
        input  busy, done, result, cout, overflow
    );

    // Sequencer side
    modport slave (
        input  start, sub, op_a, op_b,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell reused LSB-first
// over WIDTH cycles, with a start/done handshake and carry/overflow flags.

// 1-bit full-adder cell; the only combinational arithmetic in the block.
module serial_add_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_sum, fa_cout;

    // The shared adder cell always sees the current LSBs and stored carry
    serial_add_fa u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .cin (carry_q),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    // Next-state: accept operands, shift one bit per RUN cycle, latch result on the MSB
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + 1: invert B here, seed carry with 1
                    a_sh_d  = bus.op_a;
                    b_sh_d  = bus.op_b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB at this point
                    result_d = {fa_sum, res_sh_q[WIDTH-1:1]};
                    cout_d   = fa_cout;
                    ovf_d    = carry_q ^ fa_cout;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule
